cla_iterative_divider: RTL

- Multi-cycle unsigned 32-bit divider for the RISC-V datapath (DIVU/REMU, and the magnitude core for DIV/REM).
- Sits directly downstream of the 32-bit carry-lookahead adder (`cla`). It instantiates UNROLL copies of `cla`, each used as a trial subtractor.
- Restoring division, UNROLL quotient bits per cycle, with valid/ready handshakes on both sides.

---
 rtl/cla_iterative_divider_if.sv | 24 ++
 rtl/cla_iterative_divider.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cla_iterative_divider_if.sv
// Operand/result handshake bundle for the iterative divider.
interface cla_iterative_divider_if;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_dividend;
  logic [31:0] i_divisor;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_quotient;
  logic [31:0] o_remainder;
  logic        o_busy;

  // Upstream producer / downstream consumer side
  modport master (
    output i_valid, i_dividend, i_divisor, i_ready,
    input  o_ready, o_valid, o_quotient, o_remainder, o_busy
  );

  // Divider side
  modport slave (
    input  i_valid, i_dividend, i_divisor, i_ready,
    output o_ready, o_valid, o_quotient, o_remainder, o_busy
  );
endinterface

// File: rtl/cla_iterative_divider.sv
// Unsigned 32-bit restoring divider, UNROLL quotient bits per cycle,
// built from chained 32-bit carry-lookahead trial subtractors.

// 32-bit carry-lookahead adder, 4-bit lookahead groups, no carry-out.
module cla (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o
);
  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c;
  logic        carry;
  logic        grp_g;
  logic        grp_p;

  // Group-level lookahead: each group's carry-in comes from the previous group's G/P
  always_comb begin
    g     = a_i & b_i;
    p     = a_i ^ b_i;
    c     = '0;
    carry = cin_i;
    grp_g = 1'b0;
    grp_p = 1'b0;
    for (int unsigned blk = 0; blk < 8; blk++) begin
      c[blk*4]     = carry;
      c[blk*4 + 1] = g[blk*4] | (p[blk*4] & carry);
      c[blk*4 + 2] = g[blk*4 + 1] | (p[blk*4 + 1] & g[blk*4])
                   | (p[blk*4 + 1] & p[blk*4] & carry);
      c[blk*4 + 3] = g[blk*4 + 2] | (p[blk*4 + 2] & g[blk*4 + 1])
                   | (p[blk*4 + 2] & p[blk*4 + 1] & g[blk*4])
                   | (p[blk*4 + 2] & p[blk*4 + 1] & p[blk*4] & carry);
      grp_g = g[blk*4 + 3] | (p[blk*4 + 3] & g[blk*4 + 2])
            | (p[blk*4 + 3] & p[blk*4 + 2] & g[blk*4 + 1])
            | (p[blk*4 + 3] & p[blk*4 + 2] & p[blk*4 + 1] & g[blk*4]);
      grp_p = &p[blk*4 +: 4];
      carry = grp_g | (grp_p & carry);
    end
    sum_o = p ^ c;
  end
endmodule

module cla_iterative_divider #(
  parameter int unsigned UNROLL = 1  // 1, 2 or 4
) (
  input logic                   clk,
  input logic                   rst,   // asynchronous, active-low
  cla_iterative_divider_if.slave bus
);
  localparam int unsigned STEPS = 32 / UNROLL;
  localparam int unsigned CW    = 6;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   rem_q, rem_d;
  logic [31:0]   sr_q, sr_d;
  logic [31:0]   dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   quo_q, quo_d;
  logic [31:0]   remo_q, remo_d;
  logic          valid_q, valid_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;

  logic [31:0]   dvs_n;
  logic [31:0]   rem_step;
  logic [31:0]   sr_step;

  assign dvs_n = ~dvs_q;

  // Restoring steps chained combinationally; shift register holds dividend bits then quotient bits
  for (genvar k = 0; k < UNROLL; k++) begin : g_step
    logic [31:0] rem_in, sr_in, shifted, diff, rem_out, sr_out;
    logic        top, cout, accept;

    if (k == 0) begin : g_first
      assign rem_in = rem_q;
      assign sr_in  = sr_q;
    end else begin : g_next
      assign rem_in = g_step[k-1].rem_out;
      assign sr_in  = g_step[k-1].sr_out;
    end

    assign top     = rem_in[31];
    assign shifted = {rem_in[30:0], sr_in[31]};

    cla u_sub (
      .a_i   (shifted),
      .b_i   (dvs_n),
      .cin_i (1'b1),
      .sum_o (diff)
    );

    // Carry-out rebuilt from the MSBs: no borrow means shifted >= divisor
    assign cout    = (shifted[31] & dvs_n[31]) | ((shifted[31] ^ dvs_n[31]) & ~diff[31]);
    assign accept  = top | cout;
    assign rem_out = accept ? diff : shifted;
    assign sr_out  = {sr_in[30:0], accept};
  end

  assign rem_step = g_step[UNROLL-1].rem_out;
  assign sr_step  = g_step[UNROLL-1].sr_out;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      sr_q    <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      remo_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sr_q    <= sr_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sr_d    = sr_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          dvs_d   = bus.i_divisor;
          sr_d    = bus.i_dividend;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        rem_d = rem_step;
        sr_d  = sr_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_d == CW'(STEPS)) begin
          quo_d   = sr_step;
          remo_d  = rem_step;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.i_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  assign bus.o_ready     = ready_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_quotient  = quo_q;
  assign bus.o_remainder = remo_q;
endmodule
